// File: rtl/reg_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_stage
// Purpose  : Write-back merge of ALU and load results into one registered
//            register-file write port, with load FIFO and busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module reg_wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_waddr,
    input  logic [DATA_WIDTH-1:0] alu_wdata,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_waddr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_waddr,
    input  logic [ADDR_WIDTH-1:0] chk_raddr1,
    input  logic [ADDR_WIDTH-1:0] chk_raddr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int c_NUM_REGS = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] r_fifo_addr [2];
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;
    logic                  r_is_load;
    logic [c_NUM_REGS-1:0] r_busy;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_ld_fire;
    logic                  w_deq;
    logic                  w_enq;
    logic                  w_sel_valid;
    logic                  w_sel_is_load;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [c_NUM_REGS-1:0] w_busy_next;

    assign w_full    = (r_count == 2'd2);
    assign w_empty   = (r_count == 2'd0);
    assign ld_ready  = !w_full && !rst;
    assign w_ld_fire = ld_valid && ld_ready;

    // Priority: ALU, then oldest buffered load, then a same-cycle load bypass.
    always_comb begin
        w_sel_valid   = 1'b0;
        w_sel_is_load = 1'b0;
        w_sel_addr    = '0;
        w_sel_data    = '0;
        w_deq         = 1'b0;
        w_enq         = w_ld_fire;
        if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = alu_waddr;
            w_sel_data  = alu_wdata;
        end else if (!w_empty) begin
            w_sel_valid   = 1'b1;
            w_sel_is_load = 1'b1;
            w_sel_addr    = r_fifo_addr[r_rd_ptr];
            w_sel_data    = r_fifo_data[r_rd_ptr];
            w_deq         = 1'b1;
        end else if (w_ld_fire) begin
            w_sel_valid   = 1'b1;
            w_sel_is_load = 1'b1;
            w_sel_addr    = ld_waddr;
            w_sel_data    = ld_wdata;
            w_enq         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_enq) begin
                r_fifo_addr[r_wr_ptr] <= ld_waddr;
                r_fifo_data[r_wr_ptr] <= ld_wdata;
                r_wr_ptr              <= !r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Writes to register 0 are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            r_is_load <= 1'b0;
        end else begin
            rf_wen    <= w_sel_valid && (w_sel_addr != '0);
            rf_waddr  <= w_sel_addr;
            rf_wdata  <= w_sel_data;
            r_is_load <= w_sel_is_load;
        end
    end

    // Clear is applied before set so a same-address issue keeps the bit busy.
    always_comb begin
        w_busy_next = r_busy;
        if (rf_wen && r_is_load) begin
            w_busy_next[rf_waddr] = 1'b0;
        end
        if (iss_valid && (iss_waddr != '0)) begin
            w_busy_next[iss_waddr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign busy1 = r_busy[chk_raddr1];
    assign busy2 = r_busy[chk_raddr2];

endmodule
`default_nettype wire

// File: doc/reg_wb_stage.md
# reg_wb_stage

Write-back stage directly upstream of the processor's register file. It merges single-cycle ALU results and handshaked load results into one registered write port (`rf_wen`/`rf_waddr`/`rf_wdata`) that drives the register file. It buffers load results in a 2-entry FIFO while the ALU holds the port. It also keeps a per-register busy scoreboard so decode can stall on registers with an outstanding load.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: write data width.
- `ADDR_WIDTH`, default 5: register address width; 2**ADDR_WIDTH registers.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `alu_valid`  in  1  ALU result present this cycle; never back-pressured.
- `alu_waddr`  in  ADDR_WIDTH  ALU destination register.
- `alu_wdata`  in  DATA_WIDTH  ALU result.
- `ld_valid`  in  1  load result offered.
- `ld_ready`  out  1  load result accepted when `ld_valid & ld_ready`.
- `ld_waddr`  in  ADDR_WIDTH  load destination register.
- `ld_wdata`  in  DATA_WIDTH  load data.
- `iss_valid`  in  1  a load is issued this cycle.
- `iss_waddr`  in  ADDR_WIDTH  destination of the issued load.
- `chk_raddr1`, `chk_raddr2`  in  ADDR_WIDTH  decode source registers.
- `busy1`, `busy2`  out  1  combinational busy bit for `chk_raddr1`/`chk_raddr2`.
- `rf_wen`  out  1  registered write enable to the register file.
- `rf_waddr`  out  ADDR_WIDTH  registered write address.
- `rf_wdata`  out  DATA_WIDTH  registered write data.

## Operation
- Source select, evaluated each cycle in priority order:
  1. ALU, if `alu_valid`.
  2. Otherwise the FIFO head, if the FIFO is non-empty.
  3. Otherwise the incoming load handshake, as a bypass; it is not enqueued.
- Load enqueue: a handshaked load is enqueued unless it took the bypass path. Simultaneous dequeue and enqueue is allowed; order is preserved.
- FIFO: depth 2 with wrapping 1-bit read and write pointers and a 2-bit count. `ld_ready = !full & !rst`, so a full FIFO deasserts ready even in a cycle where it dequeues.
- Register 0: a selected write with address 0 is consumed (dequeued or accepted) but produces `rf_wen=0`.
- Write register: on each edge, `rf_wen`/`rf_waddr`/`rf_wdata` load the selected entry. An internal flag `rf_is_load` records whether that entry came from a load.
- Scoreboard (2**ADDR_WIDTH bits):
  - Set: `iss_valid & iss_waddr!=0` sets `busy[iss_waddr]`.
  - Clear: `rf_wen & rf_is_load` clears `busy[rf_waddr]` on the same edge the register file captures the data.
  - Set and clear of the same address in one cycle: set wins.
  - `busy[0]` is constant 0.
- Issuing a load to an already-busy register is a protocol violation. Upstream must stall on `busy` first; no WAW tracking.
- The ALU and load paths are not ordered against each other. Upstream guarantees an ALU write never targets a busy register.

## Timing
- Reset values: `rf_wen=0`, `rf_waddr=0`, `rf_wdata=0`, `rf_is_load=0`, FIFO empty, all busy bits 0, `ld_ready=0` while `rst` is high and 1 the cycle after.
- Reset mid-operation discards all buffered loads and pending busy bits.
- ALU latency: result at cycle N appears on `rf_*` at N+1.
- Load latency: a bypassed load at N appears at N+1. A queued load appears at the first cycle after N with no `alu_valid`, plus 1.
- Busy clear: `busyX` drops the cycle after the load's `rf_wen` pulse, i.e. when the register file contents are valid.
- Back-to-back: one write per cycle, sustained. Continuous `alu_valid` starves loads, and `ld_ready` falls after two accepted loads.

## Test plan
- Reset: assert `rst` with `alu_valid=1`, `ld_valid=1` → `rf_wen=0`, `ld_ready=0`, all busy=0; one cycle after release `ld_ready=1`.
- ALU path: `alu_valid`, addr 3, data 0xDEADBEEF at N → N+1 `rf_wen=1`, addr 3, data 0xDEADBEEF; addr 0 → `rf_wen=0`.
- Load bypass and scoreboard:
  - Stimulus: `iss_valid` addr 7, then `ld_valid` addr 7 data 0x55 with the ALU idle at N.
  - Required: `busy1` (`chk_raddr1=7`) high from the issue edge; `rf_wen` addr 7 at N+1; `busy1=0` at N+2.
- Contention: `alu_valid` for 4 cycles while `ld_valid` offers 0x11, 0x22, 0x33 → first two accepted, `ld_ready=0` after; after the ALU drops, writes 0x11 then 0x22 on consecutive cycles, then 0x33 is accepted.
- Set/clear collision: load to r5 written while a new `iss_valid` r5 arrives the same cycle → `busy[5]` stays 1.
- Reset mid-operation: FIFO holding 2 loads and busy r9 set, pulse `rst` → no further `rf_wen` from those entries; `busy[9]=0`.
